// File: rtl/victim_cache_ctrl_if.sv
// Bus bundle for victim_cache_ctrl: upstream (L1) request/response and
// downstream (L2/memory) line traffic, plus the occupancy readout.
// The controller takes the slave modport; the environment takes master.
interface victim_cache_ctrl_if #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256
);
    localparam int OCC_W = $clog2(ENTRIES) + 1;

    // upstream side
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic              mem_wdirty;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    // downstream side
    logic [ADDR_W-1:0] pmem_addr;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    // status
    logic [OCC_W-1:0]  occupancy;

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wdirty, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_addr, pmem_read, pmem_write, pmem_wdata,
        output occupancy
    );

    modport master (
        output mem_addr, mem_read, mem_write, mem_wdirty, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_addr, pmem_read, pmem_write, pmem_wdata,
        input  occupancy
    );
endinterface

// File: rtl/victim_cache_ctrl.sv
// Fully-associative victim cache between L1 and L2/memory.
// Evicted L1 lines are installed here; L1 read misses are looked up here
// first and, on a hit, the line moves back to L1 (entry invalidated).
// Dirty victims are written back downstream; clean victims are dropped.
// Build option: define VC_LRU_EN for true-LRU replacement; otherwise a
// round-robin replacement pointer is used and no age logic is built.
module victim_cache_ctrl #(
    parameter int ENTRIES  = 8,
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    victim_cache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - OFFSET_W;
    localparam int OCC_W = IDX_W + 1;

    if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_entries_chk
        $error("victim_cache_ctrl: ENTRIES must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INSTALL   = 3'd1,
        WRITEBACK = 3'd2,
        RESP      = 3'd3,
        READ_HIT  = 3'd4,
        READ_MISS = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    tgt_idx_q, tgt_idx_d;      // install target / victim / hit entry
    logic                tgt_repl_q, tgt_repl_d;    // install overwrites a valid line
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  dirty_q;
    logic [TAG_W-1:0]    tag_q  [ENTRIES];
    logic [LINE_W-1:0]   data_q [ENTRIES];
    logic [OCC_W-1:0]    occ_q;

    logic [TAG_W-1:0]    req_tag_s;
    logic [ENTRIES-1:0]  hit_vec_s;
    logic                hit_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic                full_s;
    logic [IDX_W-1:0]    free_idx_s;
    logic [IDX_W-1:0]    victim_s;
    logic                do_hit_write_s;
    logic                do_install_s;
    logic                do_invalidate_s;
    logic                unused_offset_s;

    assign req_tag_s       = bus.mem_addr[ADDR_W-1:OFFSET_W];
    assign unused_offset_s = ^bus.mem_addr[OFFSET_W-1:0];
    assign full_s          = &valid_q;
    assign hit_s           = |hit_vec_s;
    assign do_hit_write_s  = (state_q == IDLE) && bus.mem_write && hit_s;
    assign do_install_s    = (state_q == INSTALL);
    assign do_invalidate_s = (state_q == READ_HIT);

    // Tag compare across all entries; at most one entry can match, so an OR-encoder gives its index
    always_comb begin
        hit_idx_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec_s[i] = valid_q[i] && (tag_q[i] == req_tag_s);
            hit_idx_s    = hit_idx_s | (hit_vec_s[i] ? IDX_W'(i) : '0);
        end
    end

    // Lowest-indexed invalid entry (scan high to low so the lowest wins)
    always_comb begin
        free_idx_s = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            free_idx_s = valid_q[i] ? free_idx_s : IDX_W'(i);
        end
    end

`ifdef VC_LRU_EN
    logic [IDX_W-1:0] age_q [ENTRIES];   // larger age = older; ages form a permutation
    logic             touch_s;
    logic [IDX_W-1:0] touch_idx_s;

    assign touch_s     = do_hit_write_s || do_install_s;
    assign touch_idx_s = do_install_s ? tgt_idx_q : hit_idx_s;

    // Victim is the entry holding the maximum age
    always_comb begin
        victim_s = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            victim_s = (age_q[i] == IDX_W'(ENTRIES - 1)) ? IDX_W'(i) : victim_s;
        end
    end

    // Age update: touched entry becomes youngest, entries younger than it age by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                age_q[i] <= IDX_W'(ENTRIES - 1 - i);
            end
        end else if (touch_s) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (IDX_W'(i) == touch_idx_s) begin
                    age_q[i] <= '0;
                end else if (age_q[i] < age_q[touch_idx_s]) begin
                    age_q[i] <= age_q[i] + IDX_W'(1);
                end
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q;

    assign victim_s = rr_ptr_q;

    // Round-robin pointer advances each time an install displaces a valid line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else if (do_install_s && tgt_repl_q) begin
            rr_ptr_q <= rr_ptr_q + IDX_W'(1);
        end
    end
`endif

    // Next-state logic; target entry is latched when leaving IDLE
    always_comb begin
        state_d    = state_q;
        tgt_idx_d  = tgt_idx_q;
        tgt_repl_d = tgt_repl_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_write) begin
                    if (hit_s) begin
                        state_d = RESP;
                    end else if (!full_s) begin
                        state_d    = INSTALL;
                        tgt_idx_d  = free_idx_s;
                        tgt_repl_d = 1'b0;
                    end else begin
                        tgt_idx_d  = victim_s;
                        tgt_repl_d = 1'b1;
                        state_d    = dirty_q[victim_s] ? WRITEBACK : INSTALL;
                    end
                end else if (bus.mem_read) begin
                    tgt_idx_d = hit_s ? hit_idx_s : tgt_idx_q;
                    state_d   = hit_s ? READ_HIT : READ_MISS;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: state_d = bus.pmem_resp ? INSTALL : WRITEBACK;
            INSTALL:   state_d = RESP;
            RESP:      state_d = IDLE;
            READ_HIT:  state_d = IDLE;
            READ_MISS: state_d = bus.pmem_resp ? IDLE : READ_MISS;
            default:   state_d = IDLE;
        endcase
    end

    // Output decode from state; read miss passes downstream data/resp straight through
    always_comb begin
        bus.mem_rdata  = '0;
        bus.mem_resp   = 1'b0;
        bus.pmem_addr  = '0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.pmem_wdata = '0;
        case (state_q)
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                bus.pmem_addr  = {tag_q[tgt_idx_q], {OFFSET_W{1'b0}}};
                bus.pmem_wdata = data_q[tgt_idx_q];
            end
            RESP: begin
                bus.mem_resp = 1'b1;
            end
            READ_HIT: begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = data_q[tgt_idx_q];
            end
            READ_MISS: begin
                bus.pmem_read = 1'b1;
                bus.pmem_addr = {req_tag_s, {OFFSET_W{1'b0}}};
                bus.mem_rdata = bus.pmem_rdata;
                bus.mem_resp  = bus.pmem_resp;
            end
            IDLE, INSTALL: begin
                bus.mem_resp = 1'b0;
            end
            default: begin
                bus.mem_resp = 1'b0;
            end
        endcase
    end

    assign bus.occupancy = occ_q;

    // FSM state and latched target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_idx_q  <= '0;
            tgt_repl_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_idx_q  <= tgt_idx_d;
            tgt_repl_q <= tgt_repl_d;
        end
    end

    // Valid/dirty bits: install sets, write hit merges dirty, read hit hands the line back to L1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (do_install_s) begin
            valid_q[tgt_idx_q] <= 1'b1;
            dirty_q[tgt_idx_q] <= bus.mem_wdirty;
        end else if (do_hit_write_s) begin
            dirty_q[hit_idx_s] <= dirty_q[hit_idx_s] | bus.mem_wdirty;
        end else if (do_invalidate_s) begin
            valid_q[tgt_idx_q] <= 1'b0;
            dirty_q[tgt_idx_q] <= 1'b0;
        end
    end

    // Tag/data arrays; contents are qualified by valid so they need no reset
    always_ff @(posedge clk) begin
        if (do_install_s) begin
            tag_q[tgt_idx_q]  <= req_tag_s;
            data_q[tgt_idx_q] <= bus.mem_wdata;
        end else if (do_hit_write_s) begin
            data_q[hit_idx_s] <= bus.mem_wdata;
        end
    end

    // Occupancy: up on install into a free entry, down on read hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else if (do_install_s && !tgt_repl_q) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (do_invalidate_s) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end
endmodule
